mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the internal data memory (power of two).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port WB_EN  input  1  write-back enable from the EXE/MEM register.
REQ-005 SHALL have port MEM_R_EN  input  1  load request.
REQ-006 SHALL have port MEM_W_EN  input  1  store request.
REQ-007 SHALL have port ALURes  input  32  byte address for loads/stores; result for ALU ops.
REQ-008 SHALL have port STVal  input  32  store data.
REQ-009 SHALL have port dest  input  5  destination register index.
REQ-010 SHALL have port WB_EN_OUT  output  1  registered write-back enable to the WB stage.
REQ-011 SHALL have port MEM_R_EN_OUT  output  1  registered load flag, the WB mux select.
REQ-012 SHALL have port ALUResOut  output  32  registered ALURes.
REQ-013 SHALL have port memData  output  32  registered load data.
REQ-014 SHALL have port destOut  output  5  registered dest.
REQ-015 SHALL have port freeze  output  1  combinational stall to upstream stages.
REQ-016 SHALL have port err  output  1  registered one-cycle access-error pulse.

Function
REQ-017 SHALL use word index ALURes[log2(DEPTH)+1:2]; upper address bits ignored, so addresses wrap modulo DEPTH*4.
REQ-018 SHALL treat an access as legal only if exactly one of MEM_R_EN/MEM_W_EN is high and ALURes[1:0]==0.
REQ-019 SHALL implement FSM states IDLE and RD_WAIT.
REQ-020 SHALL write STVal to memory on the clock edge ending an IDLE cycle that presents a legal store; single-cycle, freeze stays 0.
REQ-021 SHALL, in IDLE with a legal load, drive freeze=1 combinationally, capture the word index, and go to RD_WAIT.
REQ-022 SHALL, at the end of that IDLE cycle, load a bubble into the output register: all outputs 0.
REQ-023 SHALL, in RD_WAIT, drive freeze=0 and read the captured word.
REQ-024 SHALL, at the end of RD_WAIT, register memData=word, WB_EN_OUT=WB_EN, MEM_R_EN_OUT=1, ALUResOut=ALURes, destOut=dest, then return to IDLE.
REQ-025 Upstream holds all inputs stable while freeze=1; the block SHALL NOT re-sample them in RD_WAIT beyond REQ-024.
REQ-026 SHALL, for non-memory ops in IDLE, register WB_EN, MEM_R_EN, ALURes and dest next edge (latency 1), memData unchanged, freeze=0.
REQ-027 SHALL, for an illegal access (misaligned, or both enables high), perform no memory write, stay in IDLE, and keep freeze=0.
REQ-028 On that edge it SHALL register WB_EN_OUT=0 and MEM_R_EN_OUT=0, and pulse err=1 for exactly one cycle.
REQ-029 SHALL return the most recent committed store to a later load of the same word (write before read; no stale data).
REQ-030 SHALL drive err=0 in every cycle not covered by REQ-028.

Reset
REQ-031 rst high SHALL immediately force state=IDLE, freeze=0, and WB_EN_OUT, MEM_R_EN_OUT, ALUResOut, memData, destOut, err all 0.
REQ-032 rst asserted mid-load (RD_WAIT) SHALL abort the load with no output update; memory contents SHALL NOT be cleared by reset.
REQ-033 First operation SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Store STVal=0xDEADBEEF to 0x10; then load 0x10 with dest=5 and WB_EN=1 -> freeze=1 for one cycle, bubble; next edge WB_EN_OUT=1, MEM_R_EN_OUT=1, memData=0xDEADBEEF, destOut=5.
REQ-035 ALU op WB_EN=1, ALURes=0x1234, dest=3 -> next edge ALUResOut=0x1234, WB_EN_OUT=1, destOut=3, freeze=0.
REQ-036 Load at 0x102 -> freeze=0, next edge err=1, WB_EN_OUT=0; err=0 the following cycle.
REQ-037 DEPTH=64: store 0x55 at 0x100, load 0x0 -> memData=0x55 (wrap-around).
REQ-038 MEM_R_EN=MEM_W_EN=1 at 0x20 with STVal=0xFFFFFFFF -> err pulse; a later load of 0x20 returns the prior contents.
REQ-039 rst pulsed while in RD_WAIT -> all outputs 0 and freeze=0 immediately, no memData update; the next load completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage with an internal word-addressed data memory.
//
// Loads take two cycles: the request cycle raises freeze and pushes a bubble
// into the output register, and the following cycle reads the captured word and
// registers the full result. Stores and plain ALU results pass through in one
// cycle. Misaligned accesses, and cycles with both load and store enables high,
// are rejected with a one-cycle err pulse and no memory side effect.
//
// Parameters
//   DEPTH         number of 32-bit words in the data memory (power of two)
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   WB_EN         write-back enable from EXE/MEM
//   MEM_R_EN      load request
//   MEM_W_EN      store request
//   ALURes        byte address for loads/stores, result for ALU ops
//   STVal         store data
//   dest          destination register index
//   WB_EN_OUT     registered write-back enable
//   MEM_R_EN_OUT  registered load flag (WB mux select)
//   ALUResOut     registered ALURes
//   memData       registered load data
//   destOut       registered dest
//   freeze        combinational stall to upstream stages
//   err           registered one-cycle access-error pulse
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALURes,
  input  logic [31:0] STVal,
  input  logic [4:0]  dest,
  output logic        WB_EN_OUT,
  output logic        MEM_R_EN_OUT,
  output logic [31:0] ALUResOut,
  output logic [31:0] memData,
  output logic [4:0]  destOut,
  output logic        freeze,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     mem_q [DEPTH];

  logic            wb_q, wb_d;
  logic            mr_q, mr_d;
  logic [31:0]     alu_q, alu_d;
  logic [31:0]     md_q, md_d;
  logic [4:0]      dst_q, dst_d;
  logic            err_q, err_d;

  logic            freeze_c;
  logic            mem_we;

  // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
  logic [AW-1:0]   word_idx;
  logic            aligned;
  logic            legal;
  logic            legal_ld;
  logic            legal_st;
  logic            bad_acc;

  assign word_idx = ALURes[AW+1:2];
  assign aligned  = (ALURes[1:0] == 2'b00);
  assign legal    = (MEM_R_EN ^ MEM_W_EN) && aligned;
  assign legal_ld = legal && MEM_R_EN;
  assign legal_st = legal && MEM_W_EN;
  assign bad_acc  = (MEM_R_EN || MEM_W_EN) && !legal;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wb_d     = wb_q;
    mr_d     = mr_q;
    alu_d    = alu_q;
    md_d     = md_q;
    dst_d    = dst_q;
    err_d    = 1'b0;
    freeze_c = 1'b0;
    mem_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (legal_ld) begin
          // Stall upstream for one cycle and emit a bubble meanwhile.
          freeze_c = 1'b1;
          idx_d    = word_idx;
          state_d  = RD_WAIT;
          wb_d     = 1'b0;
          mr_d     = 1'b0;
          alu_d    = '0;
          md_d     = '0;
          dst_d    = '0;
        end else if (bad_acc) begin
          // Rejected access: never let it reach write-back.
          wb_d  = 1'b0;
          mr_d  = 1'b0;
          alu_d = ALURes;
          dst_d = dest;
          err_d = 1'b1;
        end else begin
          // Plain ALU result or legal store; load data register is kept.
          wb_d   = WB_EN;
          mr_d   = 1'b0;
          alu_d  = ALURes;
          dst_d  = dest;
          mem_we = legal_st;
        end
      end

      RD_WAIT: begin
        // Inputs are still the held load request; the word index was captured.
        md_d    = mem_q[idx_q];
        wb_d    = WB_EN;
        mr_d    = 1'b1;
        alu_d   = ALURes;
        dst_d   = dest;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wb_q    <= 1'b0;
      mr_q    <= 1'b0;
      alu_q   <= '0;
      md_q    <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wb_q    <= wb_d;
      mr_q    <= mr_d;
      alu_q   <= alu_d;
      md_q    <= md_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the memory array has no reset; its contents survive rst and only the
  // write itself is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[word_idx] <= STVal;
    end
  end

  // Gate with rst so the stall drops the instant reset is applied.
  assign freeze       = freeze_c && !rst;

  assign WB_EN_OUT    = wb_q;
  assign MEM_R_EN_OUT = mr_q;
  assign ALUResOut    = alu_q;
  assign memData      = md_q;
  assign destOut      = dst_q;
  assign err          = err_q;

endmodule
